// File: rtl/ps2_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : ps2_cmd_sched
// Description : Command scheduler for the host-to-device channel of the PS2
//               keyboard port. Arbitrates between the SMC host path and an
//               optional keyboard init sequencer, issues one command at a
//               time to ps2_port, supervises ACK / error / timeout, retries
//               failed commands and publishes the host command status.
//
// Build option: PS2_INIT_SEQ_EN
//               defined   -> init sequencer present (0xFF then 0xF4),
//                            auto-run once after reset, re-run on
//                            init_start_i.
//               undefined -> host jobs only, init_start_i ignored,
//                            init_done_o tied high.
//
// Ports       : clk6x          system clock (48 MHz)
//               resetn         asynchronous active-low reset
//               ck1us          1 us tick, one clock wide
//               host_cmd_i     host command byte
//               host_cmd_v_i   host command strobe
//               host_busy_o    host command latched, not yet finished
//               host_stat_o    00 idle, 01 pending, FA acked, FE failed
//               init_start_i   request to (re)run the init sequence
//               init_done_o    init sequence completed (level)
//               ps2_cmd_o      byte to ps2_port
//               ps2_cmd_v_o    one-clock send strobe to ps2_port
//               ps2_busy_i     ps2_port busy
//               ps2_acked_i    ps2_port command acknowledged (1T)
//               ps2_errd_i     ps2_port command error (1T)
//
// Revision    : 1.0  initial release
// ============================================================================
module ps2_cmd_sched #(
    parameter int TIMEOUT_US = 20000,
    parameter int MAX_RETRY  = 2
) (
    input  logic       clk6x,
    input  logic       resetn,
    input  logic       ck1us,
    input  logic [7:0] host_cmd_i,
    input  logic       host_cmd_v_i,
    output logic       host_busy_o,
    output logic [7:0] host_stat_o,
    input  logic       init_start_i,
    output logic       init_done_o,
    output logic [7:0] ps2_cmd_o,
    output logic       ps2_cmd_v_o,
    input  logic       ps2_busy_i,
    input  logic       ps2_acked_i,
    input  logic       ps2_errd_i
);

    // Timeout counter is at least 15 bits, wider only if TIMEOUT_US needs it.
    localparam int               c_TMO_W     = ($clog2(TIMEOUT_US + 1) > 15) ?
                                               $clog2(TIMEOUT_US + 1) : 15;
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_US);
    localparam logic [2:0]       c_MAX_RETRY = 3'(MAX_RETRY);

    localparam logic [7:0] c_STAT_PEND = 8'h01;
    localparam logic [7:0] c_STAT_ACK  = 8'hFA;
    localparam logic [7:0] c_STAT_ERR  = 8'hFE;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_host_pend;
    logic [7:0]           r_host_byte;
    logic [7:0]           r_host_stat;
    logic [7:0]           r_cmd;
    logic                 r_job_init;
    logic                 r_job_ok;
    logic [2:0]           r_attempt;
    logic [c_TMO_W-1:0]   r_tmo_cnt;

    logic                 w_init_pend;
    logic [7:0]           w_init_byte;
    logic                 w_load;
    logic                 w_load_init;
    logic                 w_strobe;
    logic                 w_retry;
    logic                 w_done_ok;
    logic                 w_done_fail;
    logic                 w_fin_init;
    logic                 w_unused_ok;

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_init = 1'b0;
        w_strobe    = 1'b0;
        w_retry     = 1'b0;
        w_done_ok   = 1'b0;
        w_done_fail = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Init wins arbitration; host request stays latched meanwhile.
                if (w_init_pend) begin
                    w_load      = 1'b1;
                    w_load_init = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (r_host_pend) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!ps2_busy_i) begin
                    w_strobe    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A simultaneous error beats ACK; ACK beats a simultaneous
                // timeout because the ACK branch is tested first.
                if (ps2_acked_i && !ps2_errd_i) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = S_FINISH;
                end else if (ps2_errd_i || (r_tmo_cnt == c_TMO_MAX)) begin
                    if (r_attempt < c_MAX_RETRY) begin
                        w_retry     = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_done_fail = 1'b1;
                        w_state_nxt = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_fin_init = (r_state == S_FINISH) && r_job_init;

    // ------------------------------------------------------------------------
    // State register and job datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_host_pend <= 1'b0;
            r_host_byte <= 8'h00;
            r_host_stat <= 8'h00;
            r_cmd       <= 8'h00;
            r_job_init  <= 1'b0;
            r_job_ok    <= 1'b0;
            r_attempt   <= 3'd0;
            r_tmo_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load) begin
                r_cmd      <= w_load_init ? w_init_byte : r_host_byte;
                r_job_init <= w_load_init;
                r_attempt  <= 3'd0;
            end else if (w_retry) begin
                r_attempt  <= r_attempt + 3'd1;
            end

            // Saturating count of 1 us ticks since the last strobe.
            if (w_strobe) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_WAIT) && ck1us && (r_tmo_cnt != c_TMO_MAX)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_done_ok) begin
                r_job_ok <= 1'b1;
            end else if (w_done_fail) begin
                r_job_ok <= 1'b0;
            end

            // A new host command can only be accepted with no host job
            // pending, so it never collides with the host FINISH update.
            if (host_cmd_v_i && !r_host_pend) begin
                r_host_pend <= 1'b1;
                r_host_byte <= host_cmd_i;
                r_host_stat <= c_STAT_PEND;
            end else if ((r_state == S_FINISH) && !r_job_init) begin
                r_host_pend <= 1'b0;
                r_host_stat <= r_job_ok ? c_STAT_ACK : c_STAT_ERR;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Init sequencer
    // ------------------------------------------------------------------------
`ifdef PS2_INIT_SEQ_EN
    logic r_boot_done;
    logic r_init_pend;
    logic r_init_step;
    logic r_init_done;
    logic r_init_err;
    logic w_init_req;
    logic w_init_last;

    // Auto-request on the first clock after reset release.
    assign w_init_req  = init_start_i || !r_boot_done;
    // Last step finishes on success of step 1 or on any failed step.
    assign w_init_last = w_fin_init && (r_init_step || !r_job_ok);

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            r_boot_done <= 1'b0;
            r_init_pend <= 1'b0;
            r_init_step <= 1'b0;
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
        end else begin
            r_boot_done <= 1'b1;
            if (w_fin_init) begin
                if (w_init_last) begin
                    r_init_pend <= 1'b0;
                    r_init_step <= 1'b0;
                    r_init_done <= 1'b1;
                    r_init_err  <= !r_job_ok;
                end else begin
                    r_init_step <= 1'b1;
                end
            end else if (w_init_req && !r_init_pend) begin
                // Pending stays set for the whole sequence, so further
                // requests while running are absorbed here.
                r_init_pend <= 1'b1;
                r_init_step <= 1'b0;
                r_init_done <= 1'b0;
                r_init_err  <= 1'b0;
            end
        end
    end

    assign w_init_pend = r_init_pend;
    assign w_init_byte = r_init_step ? 8'hF4 : 8'hFF;
    // Rises combinationally in the FINISH cycle of the last step.
    assign init_done_o = r_init_done || w_init_last;
    // Error flag is held for debug visibility only.
    assign w_unused_ok = &{1'b0, r_init_err};
`else
    assign w_init_pend = 1'b0;
    assign w_init_byte = 8'h00;
    assign init_done_o = 1'b1;
    assign w_unused_ok = &{1'b0, init_start_i, w_fin_init};
`endif

    assign host_busy_o = r_host_pend;
    assign host_stat_o = r_host_stat;
    assign ps2_cmd_o   = r_cmd;
    assign ps2_cmd_v_o = w_strobe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_cmd_sched
// Description : Directed, self-checking bench for ps2_cmd_sched. Expected
//               strobe bytes are queued as stimulus is driven and compared
//               by a monitor whenever the scheduler strobes the port. A small
//               port responder answers strobes with ACK, error or silence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_cmd_sched;

    localparam int c_TMO = 100;

`ifdef PS2_INIT_SEQ_EN
    localparam logic c_DONE_RST = 1'b0;
`else
    localparam logic c_DONE_RST = 1'b1;
`endif

    logic       clk6x = 1'b0;
    logic       resetn;
    logic       ck1us = 1'b0;
    logic [7:0] host_cmd_i;
    logic       host_cmd_v_i;
    logic       host_busy_o;
    logic [7:0] host_stat_o;
    logic       init_start_i;
    logic       init_done_o;
    logic [7:0] ps2_cmd_o;
    logic       ps2_cmd_v_o;
    logic       ps2_busy_i;
    logic       ps2_acked_i;
    logic       ps2_errd_i;

    logic       resp_ack = 1'b0;
    logic       resp_err = 1'b0;
    logic       inj_ack  = 1'b0;
    int         resp_mode  = 0;   // 0 ack after delay, 1 error, 2 silent
    int         resp_delay = 50;  // ck1us ticks before ACK
    int         resp_t0;
    int         div = 0;
    int         tick_cnt = 0;
    int         strobe_cnt = 0;
    int         strobe_ticks[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         errors = 0;
    int         checks = 0;

    assign ps2_acked_i = resp_ack | inj_ack;
    assign ps2_errd_i  = resp_err;

    ps2_cmd_sched #(
        .TIMEOUT_US (c_TMO),
        .MAX_RETRY  (2)
    ) dut (
        .clk6x        (clk6x),
        .resetn       (resetn),
        .ck1us        (ck1us),
        .host_cmd_i   (host_cmd_i),
        .host_cmd_v_i (host_cmd_v_i),
        .host_busy_o  (host_busy_o),
        .host_stat_o  (host_stat_o),
        .init_start_i (init_start_i),
        .init_done_o  (init_done_o),
        .ps2_cmd_o    (ps2_cmd_o),
        .ps2_cmd_v_o  (ps2_cmd_v_o),
        .ps2_busy_i   (ps2_busy_i),
        .ps2_acked_i  (ps2_acked_i),
        .ps2_errd_i   (ps2_errd_i)
    );

    always #5 clk6x = ~clk6x;

    // 1 us tick every 4 clocks, counted on the edge the DUT samples it.
    always @(negedge clk6x) begin
        div   = (div == 3) ? 0 : div + 1;
        ck1us = (div == 0);
    end

    always @(posedge clk6x) begin
        if (ck1us) tick_cnt <= tick_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued byte.
    always @(negedge clk6x) begin
        if (ps2_cmd_v_o === 1'b1) begin
            strobe_cnt++;
            strobe_ticks.push_back(tick_cnt);
            chk("strobe_port_idle", {31'd0, ps2_busy_i}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("strobe_unexpected", exp_q.size(), 32'd1);
            end else begin
                exp_b = exp_q.pop_front();
                chk("strobe_byte", {24'd0, ps2_cmd_o}, {24'd0, exp_b});
            end
        end
    end

    // Port responder; drops its pending answer when reset is asserted.
    always begin
        @(negedge clk6x);
        while (ps2_cmd_v_o === 1'b1) begin
            resp_t0 = tick_cnt;
            if (resp_mode == 0) begin
                while (resetn === 1'b1 && tick_cnt < resp_t0 + resp_delay) @(negedge clk6x);
                if (resetn === 1'b1) begin
                    resp_ack = 1'b1;
                    @(negedge clk6x);
                    resp_ack = 1'b0;
                end
            end else if (resp_mode == 1) begin
                repeat (3) @(negedge clk6x);
                if (resetn === 1'b1) begin
                    resp_err = 1'b1;
                    @(negedge clk6x);
                    resp_err = 1'b0;
                end
            end else begin
                @(negedge clk6x);
            end
        end
    end

    task automatic host_send(input logic [7:0] b);
        @(negedge clk6x);
        host_cmd_i   = b;
        host_cmd_v_i = 1'b1;
        @(negedge clk6x);
        host_cmd_v_i = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (host_busy_o === 1'b1 && n < max_cyc) begin
            @(negedge clk6x);
            n++;
        end
        chk(tag, {31'd0, host_busy_o}, 32'd0);
    endtask

    task automatic wait_strobe(input int base, input int max_cyc, input string tag);
        int n = 0;
        while (strobe_cnt <= base && n < max_cyc) begin
            @(negedge clk6x);
            n++;
        end
        chk(tag, strobe_cnt - base, 32'd1);
    endtask

    task automatic wait_init(input int max_cyc, input string tag);
        int n = 0;
        while (init_done_o !== 1'b1 && n < max_cyc) begin
            @(negedge clk6x);
            n++;
        end
        chk(tag, {31'd0, init_done_o}, 32'd1);
    endtask

    initial begin
        int base;
        int gap;
        resetn       = 1'b0;
        host_cmd_i   = 8'h00;
        host_cmd_v_i = 1'b0;
        init_start_i = 1'b0;
        ps2_busy_i   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk6x);
        chk("rst_busy", {31'd0, host_busy_o}, 32'd0);
        chk("rst_stat", {24'd0, host_stat_o}, 32'h00);
        chk("rst_cmd", {24'd0, ps2_cmd_o}, 32'h00);
        chk("rst_strobe", {31'd0, ps2_cmd_v_o}, 32'd0);
        chk("rst_init_done", {31'd0, init_done_o}, {31'd0, c_DONE_RST});
        resetn = 1'b1;

`ifdef PS2_INIT_SEQ_EN
        resp_mode  = 0;
        resp_delay = 10;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF4);
        wait_init(2000, "boot_init_done");
        chk("boot_stat_untouched", {24'd0, host_stat_o}, 32'h00);
`endif

        // 1: host ED, ACK 50 us later, strobe at N+2
        resp_mode  = 0;
        resp_delay = 50;
        base = strobe_cnt;
        exp_q.push_back(8'hED);
        host_send(8'hED);
        chk("t1_busy", {31'd0, host_busy_o}, 32'd1);
        chk("t1_stat_pend", {24'd0, host_stat_o}, 32'h01);
        chk("t1_no_early_strobe", {31'd0, ps2_cmd_v_o}, 32'd0);
        @(negedge clk6x);
        chk("t1_strobe_n2", {31'd0, ps2_cmd_v_o}, 32'd1);
        chk("t1_cmd", {24'd0, ps2_cmd_o}, 32'hED);
        host_send(8'h55);  // ignored while busy
        chk("t1_stat_hold", {24'd0, host_stat_o}, 32'h01);
        wait_idle(1000, "t1_done");
        chk("t1_stat_ack", {24'd0, host_stat_o}, 32'hFA);
        chk("t1_strobes", strobe_cnt - base, 32'd1);

        // 2: host F3, error on every attempt
        resp_mode = 1;
        base = strobe_cnt;
        repeat (3) exp_q.push_back(8'hF3);
        host_send(8'hF3);
        wait_idle(500, "t2_done");
        chk("t2_strobes", strobe_cnt - base, 32'd3);
        chk("t2_stat_err", {24'd0, host_stat_o}, 32'hFE);

        // 3: host EE, no response, timeout retries
        resp_mode = 2;
        base = strobe_cnt;
        repeat (3) exp_q.push_back(8'hEE);
        host_send(8'hEE);
        wait_idle(3000, "t3_done");
        chk("t3_strobes", strobe_cnt - base, 32'd3);
        if (strobe_ticks.size() >= base + 3) begin
            gap = strobe_ticks[base + 1] - strobe_ticks[base];
            chk("t3_gap1_ge_tmo", {31'd0, gap >= c_TMO}, 32'd1);
            gap = strobe_ticks[base + 2] - strobe_ticks[base + 1];
            chk("t3_gap2_ge_tmo", {31'd0, gap >= c_TMO}, 32'd1);
        end
        chk("t3_stat_err", {24'd0, host_stat_o}, 32'hFE);

`ifdef PS2_INIT_SEQ_EN
        // 4: host command during init step 0xFF
        resp_mode  = 0;
        resp_delay = 20;
        base = strobe_cnt;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF4);
        exp_q.push_back(8'h20);
        @(negedge clk6x);
        init_start_i = 1'b1;
        @(negedge clk6x);
        init_start_i = 1'b0;
        chk("t4_done_cleared", {31'd0, init_done_o}, 32'd0);
        wait_strobe(base, 20, "t4_ff_strobe");
        host_send(8'h20);
        chk("t4_stat_pend", {24'd0, host_stat_o}, 32'h01);
        wait_init(1000, "t4_init_done");
        chk("t4_host_after_init", strobe_cnt - base, 32'd2);
        chk("t4_stat_still_pend", {24'd0, host_stat_o}, 32'h01);
        wait_idle(1000, "t4_done");
        chk("t4_stat_ack", {24'd0, host_stat_o}, 32'hFA);
        chk("t4_strobes", strobe_cnt - base, 32'd3);
`endif

        // 5: port busy for 200 cycles while host command pending
        resp_mode  = 0;
        resp_delay = 5;
        ps2_busy_i = 1'b1;
        base = strobe_cnt;
        exp_q.push_back(8'hF0);
        host_send(8'hF0);
        repeat (200) @(negedge clk6x);
        chk("t5_no_strobe_busy", strobe_cnt - base, 32'd0);
        chk("t5_stat_pend", {24'd0, host_stat_o}, 32'h01);
        @(posedge clk6x);
        #2 ps2_busy_i = 1'b0;
        wait_idle(500, "t5_done");
        chk("t5_strobes", strobe_cnt - base, 32'd1);
        chk("t5_stat_ack", {24'd0, host_stat_o}, 32'hFA);

        // 6: reset during WAIT, stale ACK after release
        resp_mode  = 0;
        resp_delay = 60;
        base = strobe_cnt;
        exp_q.push_back(8'h5A);
        host_send(8'h5A);
        wait_strobe(base, 20, "t6_strobe");
        repeat (5) @(negedge clk6x);
        #3 resetn = 1'b0;
        #1;
        chk("t6_async_busy", {31'd0, host_busy_o}, 32'd0);
        chk("t6_async_stat", {24'd0, host_stat_o}, 32'h00);
        chk("t6_async_cmd", {24'd0, ps2_cmd_o}, 32'h00);
        chk("t6_async_strobe", {31'd0, ps2_cmd_v_o}, 32'd0);
        chk("t6_async_init_done", {31'd0, init_done_o}, {31'd0, c_DONE_RST});
        repeat (3) @(negedge clk6x);
        resetn  = 1'b1;
        inj_ack = 1'b1;
        @(negedge clk6x);
        inj_ack = 1'b0;
        chk("t6_stale_busy", {31'd0, host_busy_o}, 32'd0);
        chk("t6_stale_stat", {24'd0, host_stat_o}, 32'h00);
`ifdef PS2_INIT_SEQ_EN
        resp_delay = 10;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF4);
        wait_init(2000, "t6_reinit_done");
        chk("t6_stat_after", {24'd0, host_stat_o}, 32'h00);
`else
        base = strobe_cnt;
        repeat (20) @(negedge clk6x);
        chk("t6_no_strobe", strobe_cnt - base, 32'd0);
        chk("t6_stat_after", {24'd0, host_stat_o}, 32'h00);
`endif

        repeat (5) @(negedge clk6x);
        chk("sb_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ps2_cmd_sched.md
Name: ps2_cmd_sched

Overview:
- Command scheduler for the single host-to-device (TX) channel of the PS2 keyboard port.
- Shares the channel between two requesters:
  - the SMC host path, fed by I2C register 0x19 writes;
  - an internal keyboard init sequencer.
- Issues commands to the port one at a time, supervises ACK/NACK/timeout, retries failed commands and publishes the 8-bit command status that the SMC reads back at register 0x18.
- Sits between the smc register logic and ps2_port; the ck1us pulse comes from the existing 1 us pulser.

Parameters:
- TIMEOUT_US, 20000, ck1us pulses allowed from command strobe to ACK/error before the attempt counts as failed.
- MAX_RETRY, 2, extra attempts after a failed first attempt (total attempts = MAX_RETRY+1); 0..7.

Ports:
- clk6x  in  1  system clock, 48 MHz.
- resetn  in  1  reset, asynchronous assert, active-low.
- ck1us  in  1  1 us tick, 1T wide.
- host_cmd_i  in  8  command byte from SMC register 0x19.
- host_cmd_v_i  in  1  1T strobe, host_cmd_i valid.
- host_busy_o  out  1  host command latched and not yet finished.
- host_stat_o  out  8  00 idle, 01 pending, FA acked, FE error/timeout.
- init_start_i  in  1  1T request to (re)run the init sequence.
- init_done_o  out  1  init sequence completed (level).
- ps2_cmd_o  out  8  byte to ps2_port cmd_tx_i.
- ps2_cmd_v_o  out  1  1T send strobe to ps2_port cmd_tx_v_i.
- ps2_busy_i  in  1  ps2_port busy.
- ps2_acked_i  in  1  ps2_port tx_acked (1T).
- ps2_errd_i  in  1  ps2_port tx_errd (1T).

Behaviour:

Reset values:
- On resetn=0, immediately (async): all outputs 0, host_stat_o=00, FSM in IDLE, both request latches clear, counters 0.

Requests:
- host_cmd_v_i with no host request pending: latch the byte, host_busy_o=1 and host_stat_o=01 from the next cycle.
- host_cmd_v_i while host_busy_o=1: ignored; latch and status unchanged.
- init_start_i: sets the init-pending flag and clears init_done_o. Repeated pulses while init is pending or running have no additional effect.

Arbitration (in IDLE only):
- Init has priority over host. An in-flight command is never pre-empted.
- Host requests arriving during init stay latched and are served after init finishes.

FSM states:
- IDLE:
  - Select the next requester (init first, then host); load the byte and attempt counter = 0; go to ISSUE.
  - Nothing pending: stay in IDLE.
- ISSUE:
  - Wait for ps2_busy_i=0, then drive ps2_cmd_v_o=1 for exactly 1 cycle with ps2_cmd_o stable.
  - Clear the timeout counter; go to WAIT.
  - ps2_cmd_o holds its value until the next ISSUE.
- WAIT:
  - Count ck1us pulses.
  - ps2_acked_i: success, go to FINISH.
  - ps2_errd_i, or the count reaching TIMEOUT_US: failure.
    - If attempt < MAX_RETRY: attempt+1, return to ISSUE.
    - Otherwise: final failure, go to FINISH.
  - ps2_acked_i and ps2_errd_i in the same cycle: treat as error.
  - Timeout and ACK in the same cycle: treat as ACK.
- FINISH (1 cycle):
  - Host job: host_stat_o = FA on success, FE on failure; clear host_busy_o.
  - Init job: advance the init step pointer.
    - A failed init step aborts the sequence with init_done_o=1 and the internal error flag set.
  - Return to IDLE.

Timing and widths:
- Strobe latency: host_cmd_v_i at cycle N, port idle, no init pending → ps2_cmd_v_o at cycle N+2.
- Timeout counter: 15 bits minimum, saturating.
- Attempt counter: 3 bits.
- host_stat_o keeps FA/FE until the next accepted host command, which sets it to 01.
- Init jobs never modify host_stat_o.

Optional Feature:
- Macro: PS2_INIT_SEQ_EN.
- Defined:
  - Init sequence = two commands, 0xFF (reset) then 0xF4 (enable scanning).
  - Auto-triggered once on the first clock after reset release; re-runnable with init_start_i.
  - init_done_o rises in the FINISH cycle of the last step.
- Undefined:
  - No init logic; init_start_i ignored; init_done_o tied to 1.
  - Only host jobs are scheduled.

Test Plan:
1. Host 0xED strobe, ps2_busy_i=0, ACK pulse 50 us later → ps2_cmd_v_o at N+2 with ps2_cmd_o=ED; host_stat_o 01 then FA; host_busy_o falls.
2. Host 0xF3, ps2_errd_i on every attempt, MAX_RETRY=2 → exactly 3 strobes; host_stat_o=FE.
3. Host 0xEE, no response (TIMEOUT_US set to 100 for the test) → retry strobes spaced ≥100 ck1us apart; final host_stat_o=FE.
4. With PS2_INIT_SEQ_EN, host 0x20 strobe during the init 0xFF step → strobe order FF, F4, 20; init_done_o=1 before the 0x20 strobe; host_stat_o stays 01 until the 0x20 ACK.
5. ps2_busy_i=1 held 200 cycles while a host command is pending → no strobe until busy falls, then a single strobe.
6. resetn pulsed low during WAIT → all outputs 0 asynchronously; no stale ACK accepted after release; host_stat_o=00.
